arm_regfile_sb: RTL and testbench
=================================

// Module: arm_regfile_sb
// PURPOSE
//  Parametrised ARM register file with multiple read ports and a per-register scoreboard.
//  Sits between ID (reads, destination reservation at issue) and WB (write-back, release).
//  Each read port reports a RAW hazard when its register has an in-flight writer.
//  ID stage stalls on rd_hazard or !iss_ready.
// PARAMETERS
//  DATA_W        32  register width
//  ADDR_W        4   register address width; NREG = 2**ADDR_W registers
//  N_READ        2   number of combinational read ports
//  MAX_INFLIGHT  3   max outstanding writers per register; CNT_W = $clog2(MAX_INFLIGHT+1)
// PORTS
//  clk       in   1               clock, all state updates on posedge
//  rst       in   1               reset, asynchronous, active-high
//  rd_addr   in   N_READ*ADDR_W   read addresses, port p at [p*ADDR_W +: ADDR_W]
//  rd_data   out  N_READ*DATA_W   read data, combinational
//  rd_hazard out  N_READ          1 = register of port p has pending writer(s)
//  iss_en    in   1               reserve destination iss_addr (instruction issued)
//  iss_addr  in   ADDR_W          destination being reserved
//  iss_ready out  1               cnt[iss_addr] != MAX_INFLIGHT (combinational)
//  wb_en     in   1               write-back valid
//  wb_addr   in   ADDR_W          write-back destination
//  wb_data   in   DATA_W          write-back value
//  flush     in   1               pipeline flush: drop all reservations
//  pend_any  out  1               OR of all cnt != 0
//  err       out  1               sticky protocol-error flag
// BEHAVIOUR
//  - Reset: regs[i] <= i (zero-extended), cnt[*] <= 0, err <= 0; thus pend_any=0, rd_hazard=0.
//  - Write: posedge, wb_en -> regs[wb_addr] <= wb_data. Always performed, even on error.
//  - Read: rd_data[p] = regs[rd_addr[p]]; rd_hazard[p] = (cnt[rd_addr[p]] != 0).
//  - Scoreboard per reg r, evaluated each posedge:
//      inc = iss_en & iss_ready & iss_addr==r ; dec = wb_en & wb_addr==r & cnt[r]!=0
//      inc&dec -> unchanged; inc -> +1; dec -> -1.
//  - Errors (sticky until rst): iss_en while !iss_ready (issue dropped, cnt unchanged);
//    wb_en to register with cnt==0 and no same-cycle inc (write done, cnt stays 0).
//  - flush: all cnt <= 0, then this cycle's accepted issue applied (cnt[iss_addr] <= 1).
//    wb during flush: write performed, no decrement, no err.
//  - Latency: issue/wb visible on rd_hazard/iss_ready the cycle after the edge.
//  - Reset mid-operation: async, overrides any in-progress write/issue immediately.
//  - Same-address wb+read without bypass: read returns old value until the edge.
// CONFIGURATION
//  ARM_RF_BYPASS_EN defined: if wb_en & wb_addr==rd_addr[p], rd_data[p]=wb_data and
//    rd_hazard[p] = (cnt[rd_addr[p]] > 1) (the retiring writer no longer counts).
//  Undefined: no forwarding; rd_data from array only, rd_hazard as above.
// STRUCTURE
//  Package arm_rf_pkg: DATA_W/ADDR_W/N_READ/MAX_INFLIGHT defaults, NREG, CNT_W.
//  Sub-module rf_sb_counter: one per register (generate); inputs inc, dec, clr;
//    outputs cnt, nz, full; clr has priority over dec, inc is still applied.
//  Top holds register array, read muxes, bypass, error logic.
// TESTING
//  1 rst pulse -> regs read 0..15 on all ports, rd_hazard=0, pend_any=0, err=0, iss_ready=1.
//  2 issue r3, next cycle read r3 -> rd_hazard=1; wb r3=0xDEAD -> next cycle hazard=0, read 0xDEAD.
//  3 issue r5 x3 -> iss_ready=0 for r5; 4th issue -> err=1, cnt stays 3; 3 wbs -> hazard clears.
//  4 wb r7 with cnt 0 -> r7 written, err=1; flush with cnt r2=2 and issue r4 -> r2 clear, r4 cnt=1.
//  5 BYPASS_EN: cnt r9=1, wb r9=0x1234 while reading r9 -> same cycle rd_data=0x1234, hazard=0.
//  6 assert rst mid-stream (cnt r1=2, wb pending) -> instant clear; regs back to index values.

Source files
------------

// File: rtl/arm_rf_pkg.sv
// Shared defaults for the ARM register file / scoreboard slice.
package arm_rf_pkg;

  localparam int DEF_DATA_W       = 32;
  localparam int DEF_ADDR_W       = 4;
  localparam int DEF_N_READ       = 2;
  localparam int DEF_MAX_INFLIGHT = 3;
  localparam int DEF_NREG         = 2 ** DEF_ADDR_W;

  function automatic int cnt_width(input int max_inflight);
    return $clog2(max_inflight + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_MAX_INFLIGHT);

endpackage

// File: rtl/rf_sb_counter.sv
// Per-register in-flight writer counter; clr wins over dec but a same-cycle inc still lands.
module rf_sb_counter
  import arm_rf_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int MAX   = DEF_MAX_INFLIGHT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             nz,
  output logic             full
);

  logic [CNT_W-1:0] cnt_r;

  // outstanding-writer count update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= inc ? CNT_W'(1) : {CNT_W{1'b0}};
    end else if (inc && !dec) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else if (dec && !inc) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign nz   = (cnt_r != {CNT_W{1'b0}});
  assign full = (cnt_r == CNT_W'(MAX));

endmodule

// File: rtl/arm_regfile_sb.sv
// Register file with N_READ read ports and per-register RAW scoreboard.
// Optional write-back forwarding onto the read ports: define ARM_RF_BYPASS_EN.
module arm_regfile_sb
  import arm_rf_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int N_READ       = DEF_N_READ,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_READ*ADDR_W-1:0]   rd_addr,
  output logic [N_READ*DATA_W-1:0]   rd_data,
  output logic [N_READ-1:0]          rd_hazard,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  output logic                       iss_ready,
  input  logic                       wb_en,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       flush,
  output logic                       pend_any,
  output logic                       err
);

  localparam int NREG  = 2 ** ADDR_W;
  localparam int CNT_W = cnt_width(MAX_INFLIGHT);

  logic [DATA_W-1:0] regs_r [NREG];
  logic [CNT_W-1:0]  cnt_s  [NREG];
  logic [NREG-1:0]   nz_s;
  logic [NREG-1:0]   full_s;
  logic [NREG-1:0]   inc_s;
  logic [NREG-1:0]   dec_s;
  logic              err_set_s;
  logic              err_r;

  assign iss_ready = ~full_s[iss_addr];

  // a write-back during flush neither retires a writer nor counts as an error
  for (genvar r = 0; r < NREG; r++) begin : g_sb
    assign inc_s[r] = iss_en & iss_ready & (iss_addr == ADDR_W'(r));
    assign dec_s[r] = wb_en & ~flush & nz_s[r] & (wb_addr == ADDR_W'(r));

    rf_sb_counter #(
      .CNT_W (CNT_W),
      .MAX   (MAX_INFLIGHT)
    ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (inc_s[r]),
      .dec  (dec_s[r]),
      .clr  (flush),
      .cnt  (cnt_s[r]),
      .nz   (nz_s[r]),
      .full (full_s[r])
    );
  end

  assign err_set_s = (iss_en & ~iss_ready)
                   | (wb_en & ~flush & ~nz_s[wb_addr] & ~inc_s[wb_addr]);

  // register array: index values on reset, write-back always performed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= DATA_W'(i);
      end
    end else if (wb_en) begin
      regs_r[wb_addr] <= wb_data;
    end else begin
      regs_r[wb_addr] <= regs_r[wb_addr];
    end
  end

  // sticky protocol error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | err_set_s;
    end
  end

  assign err      = err_r;
  assign pend_any = |nz_s;

  for (genvar p = 0; p < N_READ; p++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    assign addr_s = rd_addr[p*ADDR_W +: ADDR_W];

    // read mux; with forwarding the retiring writer no longer counts as pending
    always_comb begin
      rd_data[p*DATA_W +: DATA_W] = regs_r[addr_s];
      rd_hazard[p]                = (cnt_s[addr_s] != {CNT_W{1'b0}});
`ifdef ARM_RF_BYPASS_EN
      if (wb_en && (wb_addr == addr_s)) begin
        rd_data[p*DATA_W +: DATA_W] = wb_data;
        rd_hazard[p]                = (cnt_s[addr_s] > CNT_W'(1));
      end else begin
        rd_data[p*DATA_W +: DATA_W] = regs_r[addr_s];
        rd_hazard[p]                = (cnt_s[addr_s] != {CNT_W{1'b0}});
      end
`endif
    end
  end

endmodule

// File: tb/tb_arm_regfile_sb.sv
// Directed bench for arm_regfile_sb: abstract model checked every cycle plus literal pins.
module tb_arm_regfile_sb;
  import arm_rf_pkg::*;

  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int NR   = 2;
  localparam int MAXI = 3;
  localparam int NREG = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]  rd_hazard;
  logic           iss_en = 1'b0;
  logic [AW-1:0]  iss_addr = '0;
  logic           iss_ready;
  logic           wb_en = 1'b0;
  logic [AW-1:0]  wb_addr = '0;
  logic [DW-1:0]  wb_data = '0;
  logic           flush = 1'b0;
  logic           pend_any;
  logic           err;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  logic [DW-1:0] mregs [NREG];
  int            mcnt  [NREG];
  bit            merr;

  arm_regfile_sb dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_hazard(rd_hazard),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .pend_any(pend_any), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit accepted();
    return iss_en && (mcnt[iss_addr] != MAXI);
  endfunction

  // model: register values and outstanding-writer counts as plain arrays
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mregs[i] <= DW'(i);
        mcnt[i]  <= 0;
      end
      merr <= 1'b0;
    end else begin
      if (wb_en) mregs[wb_addr] <= wb_data;
      for (int r = 0; r < NREG; r++) begin
        if (flush)
          mcnt[r] <= (accepted() && iss_addr == r) ? 1 : 0;
        else
          mcnt[r] <= mcnt[r] + ((accepted() && iss_addr == r) ? 1 : 0)
                             - ((wb_en && wb_addr == r && mcnt[r] != 0) ? 1 : 0);
      end
      merr <= merr | (iss_en && !accepted())
                   | (wb_en && !flush && mcnt[wb_addr] == 0 && !(accepted() && iss_addr == wb_addr));
    end
  end

  // every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (started) begin
      bit any;
      any = 1'b0;
      for (int i = 0; i < NREG; i++) if (mcnt[i] != 0) any = 1'b1;
      for (int p = 0; p < NR; p++) begin
        logic [AW-1:0] a;
        logic [DW-1:0] ed;
        bit eh;
        a  = rd_addr[p*AW +: AW];
        ed = mregs[a];
        eh = (mcnt[a] != 0);
`ifdef ARM_RF_BYPASS_EN
        if (wb_en && wb_addr == a) begin
          ed = wb_data;
          eh = (mcnt[a] > 1);
        end
`endif
        check("model rd_data", 64'(rd_data[p*DW +: DW]), 64'(ed));
        check("model rd_hazard", 64'(rd_hazard[p]), 64'(eh));
      end
      check("model iss_ready", 64'(iss_ready), 64'(mcnt[iss_addr] != MAXI));
      check("model pend_any", 64'(pend_any), 64'(any));
      check("model err", 64'(err), 64'(merr));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    #2 rst = 1'b1;
    started = 1'b1;
    step(); step();
    rst = 1'b0;

    // 1: reset contents on both ports
    for (int i = 0; i < NREG; i++) begin
      set_rd(i, 15 - i);
      look();
      check("reset rd0", 64'(rd_data[DW-1:0]), 64'(i));
      check("reset rd1", 64'(rd_data[2*DW-1:DW]), 64'(15 - i));
    end
    check("reset hazard", 64'(rd_hazard), 64'h0);
    check("reset pend_any", 64'(pend_any), 64'h0);
    check("reset err", 64'(err), 64'h0);
    check("reset iss_ready", 64'(iss_ready), 64'h1);

    // 2: issue r3, write back 0xDEAD
    iss_en = 1'b1; iss_addr = 4'd3;
    step();
    iss_en = 1'b0; set_rd(3, 0);
    look();
    check("r3 hazard", 64'(rd_hazard[0]), 64'h1);
    wb_en = 1'b1; wb_addr = 4'd3; wb_data = 32'hDEAD;
    step();
    wb_en = 1'b0;
    look();
    check("r3 cleared", 64'(rd_hazard[0]), 64'h0);
    check("r3 data", 64'(rd_data[DW-1:0]), 64'hDEAD);

    // 3: saturate r5, overflow issue, drain
    iss_en = 1'b1; iss_addr = 4'd5; set_rd(5, 5);
    step(); step(); step();
    look();
    check("r5 full", 64'(iss_ready), 64'h0);
    step();
    iss_en = 1'b0;
    look();
    check("overflow err", 64'(err), 64'h1);
    check("r5 still pending", 64'(rd_hazard[0]), 64'h1);
    wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'h55;
    step(); step();
    wb_en = 1'b0;
    look();
    check("r5 one left", 64'(rd_hazard[0]), 64'h1);
    wb_en = 1'b1;
    step();
    wb_en = 1'b0;
    look();
    check("r5 drained", 64'(rd_hazard[0]), 64'h0);
    check("r5 ready", 64'(iss_ready), 64'h1);

    // 4: unexpected write-back, then flush with concurrent issue
    rst = 1'b1; step(); rst = 1'b0;
    look();
    check("err cleared", 64'(err), 64'h0);
    wb_en = 1'b1; wb_addr = 4'd7; wb_data = 32'h77;
    step();
    wb_en = 1'b0; set_rd(7, 7);
    look();
    check("r7 written", 64'(rd_data[DW-1:0]), 64'h77);
    check("stray wb err", 64'(err), 64'h1);
    iss_en = 1'b1; iss_addr = 4'd2;
    step(); step();
    iss_addr = 4'd4; flush = 1'b1;
    step();
    iss_en = 1'b0; flush = 1'b0; set_rd(2, 4);
    look();
    check("flush r2", 64'(rd_hazard[0]), 64'h0);
    check("flush r4 kept", 64'(rd_hazard[1]), 64'h1);
    wb_en = 1'b1; wb_addr = 4'd4; wb_data = 32'h44;
    step();
    wb_en = 1'b0;
    look();
    check("r4 single", 64'(rd_hazard[1]), 64'h0);
    check("idle pend_any", 64'(pend_any), 64'h0);

    // 5: same-cycle write-back and read of r9
    iss_en = 1'b1; iss_addr = 4'd9;
    step();
    iss_en = 1'b0; set_rd(0, 9);
    wb_en = 1'b1; wb_addr = 4'd9; wb_data = 32'h1234;
    look();
`ifdef ARM_RF_BYPASS_EN
    check("bypass data", 64'(rd_data[2*DW-1:DW]), 64'h1234);
    check("bypass hazard", 64'(rd_hazard[1]), 64'h0);
`else
    check("no bypass data", 64'(rd_data[2*DW-1:DW]), 64'h9);
    check("no bypass hazard", 64'(rd_hazard[1]), 64'h1);
`endif
    step();
    wb_en = 1'b0;
    look();
    check("r9 written", 64'(rd_data[2*DW-1:DW]), 64'h1234);

    // 6: asynchronous reset in the middle of activity
    iss_en = 1'b1; iss_addr = 4'd1;
    step(); step();
    iss_en = 1'b0;
    wb_en = 1'b1; wb_addr = 4'd1; wb_data = 32'hAAAA; set_rd(3, 7);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("async pend_any", 64'(pend_any), 64'h0);
    check("async r3", 64'(rd_data[DW-1:0]), 64'h3);
    check("async r7", 64'(rd_data[2*DW-1:DW]), 64'h7);
    check("async err", 64'(err), 64'h0);
    step();
    rst = 1'b0; wb_en = 1'b0; set_rd(1, 9);
    look();
    check("r1 not written", 64'(rd_data[DW-1:0]), 64'h1);
    check("r9 restored", 64'(rd_data[2*DW-1:DW]), 64'h9);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
